// File: rtl/alu_pkg.sv
// Shared constants for the execute unit: opcodes, instruction field positions,
// condition-flag bit indices and the control FSM state type.
package alu_pkg;

  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;
  localparam logic [4:0] OP_OR      = 5'd5;
  localparam logic [4:0] OP_AND     = 5'd6;
  localparam logic [4:0] OP_XOR     = 5'd7;
  localparam logic [4:0] OP_XNOR    = 5'd8;
  localparam logic [4:0] OP_NAND    = 5'd9;
  localparam logic [4:0] OP_NOR     = 5'd10;
  localparam logic [4:0] OP_NOT     = 5'd11;

  localparam int unsigned IR_OPER_LSB  = 27;
  localparam int unsigned IR_RDST_LSB  = 22;
  localparam int unsigned IR_RSRC1_LSB = 17;
  localparam int unsigned IR_IMM_MODE  = 16;
  localparam int unsigned IR_RSRC2_LSB = 11;

  localparam int unsigned FLAG_S = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_t;

endpackage

// File: rtl/alu_exec_unit_mul_seq.sv
// Unsigned shift-add multiplier: one partial-product add per cycle, DATA_W cycles.
// prod is the final accumulator value and is only meaningful while done is high.
module mul_seq #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   prod
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic                  busy;
  logic [CNT_W-1:0]      cnt;
  logic [2*DATA_W-1:0]   acc;
  logic [2*DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]     mplier;
  logic [2*DATA_W-1:0]   acc_nxt;

  always_comb begin
    acc_nxt = acc;
    if (mplier[0]) acc_nxt = acc + mcand;
  end

  // The last iteration's sum is exposed directly so the caller can write it
  // back at the same edge that completes the multiply.
  assign done = busy && (cnt == CNT_W'(DATA_W - 1));
  assign prod = acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{DATA_W{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute unit: register file, SGPR, single-cycle ALU, multi-cycle multiply
// control, SZVC flag generation and registered retire outputs.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic              res_valid,
  output logic [4:0]        res_rd,
  output logic [DATA_W-1:0] res_data,
  output logic              illegal,
  output logic [3:0]        flags,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] dbg_sgpr
);

  localparam int unsigned MSB = DATA_W - 1;

  state_t                state, state_nxt;
  logic [DATA_W-1:0]     gpr [NREG];
  logic [DATA_W-1:0]     sgpr;
  logic [4:0]            mul_rd;

  logic [4:0]            oper, rdst, rsrc1, rsrc2;
  logic                  imm_mode;
  logic [15:0]           imm;
  logic [DATA_W-1:0]     op1, op2, alu_res;
  logic [DATA_W:0]       sum, diff;
  logic [3:0]            alu_flags, mul_flags;
  logic                  legal, accept, is_mul;
  logic                  mul_done;
  logic [2*DATA_W-1:0]   mul_prod;

  assign oper     = instr[IR_OPER_LSB  +: 5];
  assign rdst     = instr[IR_RDST_LSB  +: 5];
  assign rsrc1    = instr[IR_RSRC1_LSB +: 5];
  assign rsrc2    = instr[IR_RSRC2_LSB +: 5];
  assign imm_mode = instr[IR_IMM_MODE];
  assign imm      = instr[15:0];

  assign op1    = gpr[rsrc1];
  assign op2    = imm_mode ? DATA_W'(imm) : gpr[rsrc2];
  assign sum    = {1'b0, op1} + {1'b0, op2};
  assign diff   = {1'b0, op1} - {1'b0, op2};
  assign is_mul = (oper == OP_MUL);
  assign accept = instr_valid && instr_ready;

  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    legal     = 1'b1;
    case (oper)
      OP_MOVSGPR: alu_res = sgpr;
      OP_MOV:     alu_res = op2;
      OP_ADD: begin
        alu_res           = sum[MSB:0];
        alu_flags[FLAG_C] = sum[DATA_W];
        alu_flags[FLAG_V] = (op1[MSB] == op2[MSB]) && (sum[MSB] != op1[MSB]);
      end
      OP_SUB: begin
        alu_res           = diff[MSB:0];
        alu_flags[FLAG_C] = diff[DATA_W];
        alu_flags[FLAG_V] = (op1[MSB] != op2[MSB]) && (diff[MSB] != op1[MSB]);
      end
      OP_MUL:     alu_res = '0;
      OP_OR:      alu_res = op1 | op2;
      OP_AND:     alu_res = op1 & op2;
      OP_XOR:     alu_res = op1 ^ op2;
      OP_XNOR:    alu_res = ~(op1 ^ op2);
      OP_NAND:    alu_res = ~(op1 & op2);
      OP_NOR:     alu_res = ~(op1 | op2);
      OP_NOT:     alu_res = ~op2;
      default:    legal   = 1'b0;
    endcase
    alu_flags[FLAG_S] = alu_res[MSB];
    alu_flags[FLAG_Z] = (alu_res == '0);
  end

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_S] = mul_prod[2*DATA_W-1];
    mul_flags[FLAG_Z] = (mul_prod == '0);
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid && is_mul) state_nxt = ST_MUL;
      end
      ST_MUL: if (mul_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_mul),
    .a     (op1),
    .b     (op2),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) gpr[i] <= '0;
      sgpr      <= '0;
      flags     <= '0;
      mul_rd    <= '0;
      res_valid <= 1'b0;
      illegal   <= 1'b0;
      res_rd    <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= 1'b0;
      illegal   <= 1'b0;
      if (accept && is_mul) begin
        mul_rd <= rdst;
      end else if (accept) begin
        res_valid <= 1'b1;
        res_rd    <= rdst;
        if (legal) begin
          gpr[rdst] <= alu_res;
          res_data  <= alu_res;
          flags     <= alu_flags;
        end else begin
          illegal  <= 1'b1;
          res_data <= '0;
        end
      end else if (mul_done) begin
        gpr[mul_rd] <= mul_prod[DATA_W-1:0];
        sgpr        <= mul_prod[2*DATA_W-1:DATA_W];
        flags       <= mul_flags;
        res_valid   <= 1'b1;
        res_rd      <= mul_rd;
        res_data    <= mul_prod[DATA_W-1:0];
      end
    end
  end

  assign dbg_data = gpr[dbg_addr];
  assign dbg_sgpr = sgpr;

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Clocked, parametrised execute unit for the micro-processor datapath: it accepts one 32-bit instruction per handshake, executes it against an internal general-purpose register file, and retires the result with registered SZVC condition flags. Single-cycle operations issue back-to-back. Multiply runs on a multi-cycle shift-add engine that returns the high half in SGPR. It sits between instruction fetch/decode and the branch/condition logic that consumes the flags.

## Interface
- DATA_W, 16, datapath and register width; legal range 16..32.
- NREG, 32, GPR count; fixed to 32 by the 5-bit register fields.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  unit can accept; accept = instr_valid & instr_ready.
- instr  in  32  instruction word: oper[31:27], rdst[26:22], rsrc1[21:17], imm_mode[16], rsrc2[15:11], imm[15:0].
- res_valid  out  1  one-cycle retire pulse.
- res_rd  out  5  retired destination register.
- res_data  out  DATA_W  value written to GPR[res_rd].
- illegal  out  1  qualifies res_valid: retired opcode was undefined.
- flags  out  4  {sign, zero, overflow, carry}, registered.
- dbg_addr  in  5  debug GPR read address.
- dbg_data  out  DATA_W  GPR[dbg_addr], combinational.
- dbg_sgpr  out  DATA_W  current SGPR.

## Operation
- Opcodes: movsgpr 0, mov 1, add 2, sub 3, mul 4, or 5, and 6, xor 7, xnor 8, nand 9, nor 10, not 11; 12..31 illegal.
- op2 = imm_mode ? zero-extend(imm) to DATA_W : GPR[rsrc2]; not uses op2 only.
- States IDLE, MUL. IDLE: instr_ready=1. Non-mul op executes at its accept edge. Accepting mul captures operands and enters MUL. MUL: instr_ready=0; one shift-add iteration per cycle, DATA_W iterations; at the last iteration write GPR[rdst]=prod[DATA_W-1:0] and SGPR=prod[2*DATA_W-1:DATA_W], then return to IDLE.
- Product is unsigned, 2*DATA_W bits.
- Flags update only on retire of a legal op:
  - S = result MSB; Z = (result==0).
  - add: C = carry-out; V = signed overflow, (a,b same sign, result differs).
  - sub: C = borrow (a < op2 unsigned); V = (a,op2 differ in sign, result sign != a).
  - mul: S = prod MSB; Z = (prod==0); C=V=0.
  - all others: C=V=0.
- Illegal op: retires like a single-cycle op with illegal=1; no GPR/SGPR/flag change; res_data=0.
- Reset: all GPR=0, SGPR=0, flags=0, res_valid=0, illegal=0, res_rd=0, res_data=0, state IDLE (instr_ready=1).

## Timing
- Single-cycle op accepted at edge E0: GPR and flags updated at E0; res_valid=1 in cycle after E0. Throughput 1/cycle.
- mul accepted at E0: iterations at E1..E_DATA_W; write and flags at E_DATA_W; res_valid in cycle after E_DATA_W; next accept earliest at E_DATA_W+1.
- No hazards: a dependent instruction accepted at the next edge reads the already-written GPR.
- rst_n low mid-MUL: abort, no write, no res_valid; all state takes reset values immediately.
- rdst equal to a source: old value is read, new value is written at the same edge.

## Structure
- Package alu_pkg: opcode constants, IR field bit positions, flag bit indices {S=3,Z=2,V=1,C=0}, state enum.
- Sub-module mul_seq: start/done shift-add multiplier, parametrised by DATA_W, producing a 2*DATA_W-bit product.
- Top level holds the register file, SGPR, FSM, flag logic and retire registers.

## Test plan
- After reset: mov r1, imm 0x8000 -> next cycle res_valid=1, res_rd=1, res_data=0x8000, flags=S1 Z0 V0 C0; dbg_data(r0)=0.
- add r2=r1(0x7FFF)+imm 1 -> 0x8000, S1 V1 C0. Then add r3=r2+r2 -> 0x0000, Z1 V1 C1. Both issue on consecutive cycles.
- sub r4 = r5(0x0001) - imm 2 -> 0xFFFF, S1 C1 V0. Then sub r6 = r7(0x8000) - imm 1 -> 0x7FFF, V1 C0.
- mul r8 = r9(0xFFFF) * r9 -> instr_ready low 16 cycles; res_valid 16 cycles after accept; r8=0x0001, SGPR=0xFFFE, S1 Z0. Then movsgpr r10 -> 0xFFFE.
- rst_n low at MUL iteration 8 -> rdst stays 0, SGPR=0, no res_valid, instr_ready=1 after release.
- Opcode 31 -> res_valid=1, illegal=1, GPRs and flags unchanged. Repeat mul test with DATA_W=32: 0xFFFFFFFF² -> low 0x00000001, SGPR 0xFFFFFFFE.
